fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage of the core. It issues in-order read requests to instruction memory, tracks outstanding reads, and buffers the returned words with their PCs in a small FIFO. It presents the buffered words to decode_1 through a valid/ready handshake. On a redirect (jump/branch) it flushes the buffer and silently discards responses that were already in flight.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, FIFO entries and also the maximum number of requests in flight plus buffered words (power of 2, 2..16)

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  asynchronous, active-low reset
INST_RDEN  out  1  read request valid
INST_RADDR  out  32  read request address; word aligned
INST_RVALID  in  1  read response valid; responses return in request order
INST_RDATA  in  32  read response data
MEM_WAIT  in  1  memory not accepting; a request is accepted at an edge where INST_RDEN=1 and MEM_WAIT=0
JMP_DO  in  1  redirect strobe, one cycle
JMP_PC  in  32  redirect target; bits [1:0] are ignored and treated as 0
FETCH_VALID  out  1  output word valid (to decode_1)
FETCH_PC  out  32  PC of the output word
FETCH_DATA  out  32  instruction word
FETCH_READY  in  1  decode_1 accepts the word; a pop occurs when FETCH_VALID and FETCH_READY are both 1

Behaviour:
- Reset (RST=0, asynchronous):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, discard=0, FIFO empty.
  - INST_RDEN=0, FETCH_VALID=0, FETCH_PC=0, FETCH_DATA=0.
  - Reset mid-operation drops all in-flight state. Responses arriving after reset release are treated as stale only if the memory was also reset; the bench resets both together.
- Request issue:
  - INST_RDEN = (fifo_count + outstanding < DEPTH) && !JMP_DO. This is combinational from registers plus JMP_DO.
  - INST_RADDR = fetch_pc.
  - While MEM_WAIT=1, INST_RDEN and INST_RADDR hold stable unless JMP_DO arrives.
  - On acceptance: fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1.
- Response:
  - Every INST_RVALID decrements outstanding.
  - If discard>0: the word is dropped and discard -= 1.
  - Otherwise: push {resp_pc, INST_RDATA} into the FIFO and resp_pc += 4.
  - A response arriving with outstanding=0 is a protocol violation; the bench asserts on it.
- Output: FETCH_* are driven from the FIFO head.
  - A response at edge N is visible on FETCH_* after edge N; there is no combinational bypass.
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
  - The credit rule guarantees no overflow.
- Redirect (JMP_DO=1 at edge):
  - FIFO is flushed; FETCH_VALID=0 next cycle.
  - fetch_pc = resp_pc = {JMP_PC[31:2],2'b00}.
  - discard = outstanding + accepted_this_edge - rvalid_this_edge + discard_prior_adjustment, i.e. every request issued before the redirect is stale.
  - INST_RDEN is 0 in the JMP_DO cycle, so no request is accepted that cycle.
  - A response arriving in the same cycle is counted as stale and dropped.
  - A pop in the same cycle is honoured: decode_1 has sampled the word; the flush still clears the remainder.
  - A redirect while discard>0 accumulates: discard becomes the total in flight.
  - New requests may issue during the discard phase. The response order guarantees that stale words arrive first.
- Counters:
  - outstanding, discard and fifo_count are $clog2(DEPTH)+1 bits wide.
  - The invariant discard <= outstanding always holds.
- FSM: RUN (discard==0) and DRAIN (discard>0). This is informational; behaviour follows from the counters. RUN goes to DRAIN on a redirect with requests in flight. DRAIN goes to RUN when the last stale response is dropped.

Decomposition:
- Shared core package:
  - XLEN=32
  - INST_BYTES=4
  - default RESET_PC constant
  - fetch entry struct {pc[31:0], data[31:0]}
- One sub-module, fetch_fifo:
  - synchronous FIFO parameterised by DEPTH and width 64
  - push, pop and flush inputs
  - count, empty and full outputs
  - flush has priority over push

Test Plan:
- Reset release with MEM_WAIT=0, memory latency 1, FETCH_READY=1 -> INST_RADDR sequence 0,4,8,...; FETCH_PC/FETCH_DATA match the memory image in order, one per cycle sustained.
- FETCH_READY=0 for 10 cycles -> exactly DEPTH(4) requests accepted, then INST_RDEN=0. On release, words for PC 0..C come out in order, then issue resumes at 0x10.
- MEM_WAIT=1 for 3 cycles with INST_RDEN=1 at addr 0x8 -> INST_RADDR stays at 0x8. The request is accepted only on the edge after MEM_WAIT falls; no duplicate or missing PC.
- Memory latency 3 with 3 requests in flight, JMP_DO with JMP_PC=0x100 -> the 3 stale words are dropped. The first FETCH_VALID carries PC 0x100, then 0x104, ...
- JMP_DO in the same cycle as INST_RVALID and a pending pop -> the popped word is delivered once, the response is dropped, and the next output PC equals JMP_PC.
- Assert RST low mid-stream with 2 outstanding and the FIFO half full -> next cycle INST_RDEN=0 and FETCH_VALID=0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: widths, reset PC,
// the buffered fetch entry and the discard-tracking FSM states.
package fetch_unit_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, data} entries; flush wins over push and
// a push is accepted when full only if a pop frees a slot on the same edge.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order requests, response buffering,
// and redirect handling that drops every response issued before the jump.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        INST_RDEN,
  output logic [31:0] INST_RADDR,
  input  logic        INST_RVALID,
  input  logic [31:0] INST_RDATA,
  input  logic        MEM_WAIT,
  input  logic        JMP_DO,
  input  logic [31:0] JMP_PC,
  output logic        FETCH_VALID,
  output logic [31:0] FETCH_PC,
  output logic [31:0] FETCH_DATA,
  input  logic        FETCH_READY
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     r_state, w_state_nxt;
  logic [31:0]      r_fetch_pc, r_resp_pc;
  logic [CNT_W-1:0] r_outstanding, r_discard;
  logic [CNT_W-1:0] w_out_nxt, w_discard_nxt;
  logic [CNT_W-1:0] w_fifo_count;
  logic [CNT_W:0]   w_credit_used;
  logic             w_fifo_empty, w_fifo_full;
  logic             w_rden, w_accept, w_stale, w_push, w_pop;
  logic [31:0]      w_jmp_target;
  fetch_entry_t     w_wentry, w_rentry;

  assign w_jmp_target  = JMP_PC & ~32'h3;
  assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign w_rden   = RST && !JMP_DO && !w_fifo_full
                 && (w_credit_used < (CNT_W+1)'(DEPTH));
  assign w_accept = w_rden && !MEM_WAIT;
  // A response racing a redirect belongs to the old stream as well.
  assign w_stale  = INST_RVALID && ((r_state == ST_DRAIN) || JMP_DO);
  assign w_push   = INST_RVALID && !w_stale;
  assign w_pop    = FETCH_VALID && FETCH_READY;
  assign w_wentry = '{pc: r_resp_pc, data: INST_RDATA};

  always_comb begin
    w_out_nxt     = r_outstanding + CNT_W'(w_accept) - CNT_W'(INST_RVALID);
    w_discard_nxt = r_discard;
    if (JMP_DO)
      w_discard_nxt = w_out_nxt;
    else if (INST_RVALID && (r_state == ST_DRAIN))
      w_discard_nxt = r_discard - CNT_W'(1);
    w_state_nxt = (w_discard_nxt != '0) ? ST_DRAIN : ST_RUN;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state       <= ST_RUN;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_out_nxt;
      r_discard     <= w_discard_nxt;
      if (JMP_DO) begin
        r_fetch_pc <= w_jmp_target;
        r_resp_pc  <= w_jmp_target;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'(INST_BYTES);
        if (w_push)   r_resp_pc  <= r_resp_pc + 32'(INST_BYTES);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (JMP_DO),
    .i_wdata (w_wentry),
    .o_rdata (w_rentry),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign INST_RDEN   = w_rden;
  assign INST_RADDR  = r_fetch_pc;
  assign FETCH_VALID = !w_fifo_empty;
  assign FETCH_PC    = FETCH_VALID ? w_rentry.pc   : '0;
  assign FETCH_DATA  = FETCH_VALID ? w_rentry.data : '0;
endmodule
